mii_tx_frame_ctrl: RTL

Transmit-side MII frame sequencer for the 100 Mb/s RGMII/MII Ethernet path. It accepts a byte stream with valid/ready/last framing and emits one nibble per clock on the MII transmit interface. Each frame goes out as preamble, SFD, payload, optional zero pad, the IEEE 802.3 FCS, and an enforced inter-frame gap. It owns the nibble-wide CRC-32 engine: it clears the engine, enables it and reads it back.

---
 rtl/mii_tx_pkg.sv | 26 ++
 rtl/crc32_d4.sv | 40 ++++
 rtl/mii_tx_frame_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mii_tx_pkg.sv
// Shared types and constants for the MII transmit frame sequencer.
package mii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_ABORT = 3'd6,
    ST_IFG   = 3'd7
  } tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;

  // Wire order is LSB first; the CRC engine shifts MSB first.
  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/crc32_d4.sv
// CRC-32 (poly 0x04C11DB7), MSB-first, four data bits per clock.
module crc32_d4
  import mii_tx_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        enable,
  input  logic [3:0]  data,
  output logic [31:0] crc
);

  logic [31:0] w_next;

  // Four serial division steps, data[3] entering first.
  always_comb begin
    w_next = crc;
    for (int i = 3; i >= 0; i--) begin
      if (w_next[31] ^ data[i]) begin
        w_next = {w_next[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        w_next = {w_next[30:0], 1'b0};
      end
    end
  end

  // CRC register: load wins over enable; otherwise hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      crc <= CRC_INIT;
    end else if (load) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= w_next;
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/mii_tx_frame_ctrl.sv
// MII transmit frame sequencer: preamble, SFD, payload, pad, FCS, IFG.
// Line outputs are registered, so the wire lags the state by one clock.
module mii_tx_frame_ctrl
  import mii_tx_pkg::*;
#(
  parameter int MIN_BYTES        = 60,
  parameter int IFG_NIBBLES      = 24,
  parameter int PREAMBLE_NIBBLES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       pad_en,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  tx_state_t   r_state, w_state_nxt;
  logic [15:0] r_tcnt;
  logic        r_nib_hi;
  logic [7:0]  r_byte;
  logic        r_last;
  logic        r_pad_en;
  logic [10:0] r_byte_cnt;
  logic [31:0] r_fcs_sh;

  logic [3:0]  w_txd, w_nib;
  logic        w_tx_en, w_tx_er, w_done, w_underrun;
  logic        w_accept, w_cnt_inc, w_crc_load, w_crc_en;
  logic [10:0] w_cnt_plus;
  logic [31:0] w_crc, w_fcs_word, w_fcs_cur;

  crc32_d4 u_crc (
    .Clk    (Clk),
    .Reset  (Reset),
    .load   (w_crc_load),
    .enable (w_crc_en),
    .data   (bitrev4(w_nib)),
    .crc    (w_crc)
  );

  assign busy       = (r_state != ST_IDLE);
  assign w_cnt_plus = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_fcs_cur  = (r_tcnt == 16'd0) ? w_fcs_word : r_fcs_sh;

  // Wire FCS word: each engine nibble bit-reversed and inverted, kept in place so
  // the top nibble is the first one on the wire.
  always_comb begin
    w_fcs_word = 32'h0;
    for (int k = 0; k < 8; k++) begin
      w_fcs_word[4*k +: 4] = ~bitrev4(w_crc[4*k +: 4]);
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake, CRC control and pre-register line values.
  always_comb begin
    w_state_nxt = r_state;
    w_txd       = 4'h0;
    w_tx_en     = 1'b0;
    w_tx_er     = 1'b0;
    w_done      = 1'b0;
    w_underrun  = 1'b0;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_cnt_inc   = 1'b0;
    w_crc_load  = 1'b0;
    w_crc_en    = 1'b0;
    w_nib       = 4'h0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_PRE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_PRE: begin
        w_tx_en = 1'b1;
        w_txd   = PREAMBLE_NIB;
        if (r_tcnt == 16'(PREAMBLE_NIBBLES - 1)) w_state_nxt = ST_SFD;
        else                                     w_state_nxt = ST_PRE;
      end
      ST_SFD: begin
        w_tx_en    = 1'b1;
        w_txd      = SFD_NIB;
        in_ready   = 1'b1;
        w_crc_load = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_DATA: begin
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        w_nib    = r_nib_hi ? r_byte[7:4] : r_byte[3:0];
        w_txd    = w_nib;
        if (!r_nib_hi) begin
          w_state_nxt = ST_DATA;
        end else if (r_last) begin
          w_cnt_inc = 1'b1;
          if (r_pad_en && (w_cnt_plus < 11'(MIN_BYTES))) w_state_nxt = ST_PAD;
          else                                           w_state_nxt = ST_FCS;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_cnt_inc   = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_ABORT;
          end
        end
      end
      ST_PAD: begin
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (!r_nib_hi) begin
          w_state_nxt = ST_PAD;
        end else begin
          w_cnt_inc = 1'b1;
          if (w_cnt_plus >= 11'(MIN_BYTES)) w_state_nxt = ST_FCS;
          else                              w_state_nxt = ST_PAD;
        end
      end
      ST_FCS: begin
        w_tx_en = 1'b1;
        w_txd   = w_fcs_cur[31:28];
        if (r_tcnt == 16'd7) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IFG;
        end else begin
          w_state_nxt = ST_FCS;
        end
      end
      ST_ABORT: begin
        w_tx_en     = 1'b1;
        w_tx_er     = 1'b1;
        w_underrun  = 1'b1;
        w_state_nxt = ST_IFG;
      end
      ST_IFG: begin
        if (r_tcnt == 16'(IFG_NIBBLES - 1)) w_state_nxt = ST_IDLE;
        else                                w_state_nxt = ST_IFG;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: per-state cycle counter, nibble phase, byte holding, byte count, FCS shifter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tcnt     <= 16'd0;
      r_nib_hi   <= 1'b0;
      r_byte     <= 8'h00;
      r_last     <= 1'b0;
      r_pad_en   <= 1'b0;
      r_byte_cnt <= 11'd0;
      r_fcs_sh   <= 32'h0;
    end else begin
      r_tcnt   <= (w_state_nxt != r_state) ? 16'd0 : r_tcnt + 16'd1;
      r_nib_hi <= ((r_state == ST_DATA || r_state == ST_PAD) && (w_state_nxt == r_state))
                  ? ~r_nib_hi : 1'b0;
      if (r_state == ST_IDLE && in_valid) r_pad_en <= pad_en;
      if (w_accept) begin
        r_byte <= in_data;
        r_last <= in_last;
      end
      if (r_state == ST_SFD)  r_byte_cnt <= 11'd0;
      else if (w_cnt_inc)     r_byte_cnt <= w_cnt_plus;
      if (r_state == ST_FCS)  r_fcs_sh   <= {w_fcs_cur[27:0], 4'h0};
    end
  end

  // Registered MII line outputs and status pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      txd        <= 4'h0;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      txd        <= w_txd;
      tx_en      <= w_tx_en;
      tx_er      <= w_tx_er;
      frame_done <= w_done;
      underrun   <= w_underrun;
    end
  end

endmodule
